// File: rtl/forward_ctrl.sv
// forward_ctrl
// Tracks register tags through the ID/EX, EX/MEM and MEM/WB stages of a
// classic five-stage pipeline. From those tags it produces the ALU operand
// bypass selects and the load-use stall, and keeps a saturating count of
// stall cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   id_valid     decode stage holds a real instruction
//   id_rs1       decode source register A (operand 1)
//   id_rs2       decode source register B (operand 2)
//   id_rd        decode destination register
//   id_regwrite  decode instruction writes id_rd
//   id_memread   decode instruction is a load
//   flush        branch flush, next IDEX entry becomes a bubble
//   ForwardA     operand 1 select: 00 regfile, 10 EXMEM ALU result, 01 MEMWB
//   ForwardB     operand 2 select, same encoding
//   stall        load-use hazard, upstream holds PC and IF/ID while high
//   stall_count  saturating count of stall cycles
module forward_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic [3:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        stall,
  output logic [15:0] stall_count
);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  // ID/EX tag stage
  logic       idex_valid;
  logic [3:0] idex_rs1;
  logic [3:0] idex_rs2;
  logic [3:0] idex_rd;
  logic       idex_regwrite;
  logic       idex_memread;

  // EX/MEM tag stage
  logic       exmem_valid;
  logic [3:0] exmem_rd;
  logic       exmem_regwrite;
  logic       exmem_memread;

  // MEM/WB tag stage
  logic       memwb_valid;
  logic [3:0] memwb_rd;
  logic       memwb_regwrite;

  logic [15:0] stall_cnt_q;

  // A producer in EX/MEM can only be bypassed if its value is an ALU
  // result; a load's data does not exist until MEM/WB. Register 0 never
  // produces anything.
  logic exmem_fwd_ok;
  logic memwb_fwd_ok;

  assign exmem_fwd_ok = exmem_valid && exmem_regwrite && !exmem_memread &&
                        (exmem_rd != 4'd0);
  assign memwb_fwd_ok = memwb_valid && memwb_regwrite && (memwb_rd != 4'd0);

  // Load-use hazard: the instruction in ID needs a value that the load now
  // in EX will only have after MEM. Holding for one cycle lets the load reach
  // MEM/WB, where it can be bypassed.
  always_comb begin
    stall = id_valid && idex_valid && idex_memread && (idex_rd != 4'd0) &&
            ((idex_rd == id_rs1) || (idex_rd == id_rs2));
  end

  // Operand selects come from registered tags only. EX/MEM is checked first
  // because it holds the youngest value of a register written twice in a row.
  always_comb begin
    ForwardA = FWD_REGFILE;
    ForwardB = FWD_REGFILE;
    if (idex_valid) begin
      if (exmem_fwd_ok && (exmem_rd == idex_rs1))
        ForwardA = FWD_EXMEM;
      else if (memwb_fwd_ok && (memwb_rd == idex_rs1))
        ForwardA = FWD_MEMWB;

      if (exmem_fwd_ok && (exmem_rd == idex_rs2))
        ForwardB = FWD_EXMEM;
      else if (memwb_fwd_ok && (memwb_rd == idex_rs2))
        ForwardB = FWD_MEMWB;
    end
  end

  // Tag pipeline. The two later stages always advance; ID/EX takes a bubble
  // when the decode instruction is held back by a stall or killed by a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid     <= 1'b0;
      idex_rs1       <= 4'd0;
      idex_rs2       <= 4'd0;
      idex_rd        <= 4'd0;
      idex_regwrite  <= 1'b0;
      idex_memread   <= 1'b0;
      exmem_valid    <= 1'b0;
      exmem_rd       <= 4'd0;
      exmem_regwrite <= 1'b0;
      exmem_memread  <= 1'b0;
      memwb_valid    <= 1'b0;
      memwb_rd       <= 4'd0;
      memwb_regwrite <= 1'b0;
    end else begin
      exmem_valid    <= idex_valid;
      exmem_rd       <= idex_rd;
      exmem_regwrite <= idex_regwrite;
      exmem_memread  <= idex_memread;
      memwb_valid    <= exmem_valid;
      memwb_rd       <= exmem_rd;
      memwb_regwrite <= exmem_regwrite;
      if (stall || flush) begin
        idex_valid    <= 1'b0;
        idex_rs1      <= 4'd0;
        idex_rs2      <= 4'd0;
        idex_rd       <= 4'd0;
        idex_regwrite <= 1'b0;
        idex_memread  <= 1'b0;
      end else begin
        idex_valid    <= id_valid;
        idex_rs1      <= id_rs1;
        idex_rs2      <= id_rs2;
        idex_rd       <= id_rd;
        idex_regwrite <= id_regwrite;
        idex_memread  <= id_memread;
      end
    end
  end

  // Stall cycle counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= 16'd0;
    else if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;

endmodule
